// File: rtl/sr_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the serial shift-register output driver.
// FRAME_CYCLES gives the BUSY length of one frame for a given width and divider.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } sr_state_e;

    localparam int SR_STATE_W = 2;

    function automatic int cnt_width(input int clk_div);
        return (clk_div < 1) ? 1 : $clog2(clk_div + 1);
    endfunction

    function automatic int idx_width(input int n_bits);
        return (n_bits < 1) ? 1 : $clog2(n_bits + 1);
    endfunction

    function automatic int FRAME_CYCLES(input int n_bits, input int clk_div);
        return 2 * clk_div * n_bits + clk_div;
    endfunction

endpackage

// File: rtl/sr_clk_prescaler.sv
// Phase counter for the shift clock: tick_o marks the last cycle of each CLK_DIV-cycle phase.
// restart_i holds the count at zero so the first phase after it is full length.
module sr_clk_prescaler
    import sr_ctrl_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_out_ctrl_param.sv
// Parametrised 74HC595-style serialiser with load/busy/done handshake and optional auto-refresh.
// All outputs come straight from flops; SR_DATA only moves on the SR_CLK falling transition.
module sr_out_ctrl_param
    import sr_ctrl_pkg::*;
#(
    parameter int N_BITS       = 16,
    parameter int CLK_DIV      = 1,
    parameter int MSB_FIRST    = 0,
    parameter int AUTO_REFRESH = 0
) (
    input  logic              CLK_IN,
    input  logic              RST,
    input  logic [N_BITS-1:0] DATA_IN,
    input  logic              LOAD,
    output logic              BUSY,
    output logic              DONE,
    output logic              SR_CLK,
    output logic              SR_DATA,
    output logic              SR_STROBE
);

    localparam int IDX_W = idx_width(N_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
    localparam bit MSB  = (MSB_FIRST != 0);
    localparam bit AUTO = (AUTO_REFRESH != 0);

    sr_state_e         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_BITS-1:0] shadow_q, shadow_d, shadow_nx;
    logic              pending_q, pending_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              sdata_q, sdata_d;
    logic              strobe_q, strobe_d;

    logic tick;
    logic restart;
    logic load_eff;
    logic start_req;
    logic first_bit;
    logic next_bit;

    assign restart = (state_q == IDLE);

    sr_clk_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk_i    (CLK_IN),
        .rst_i    (RST),
        .restart_i(restart),
        .tick_o   (tick)
    );

    // The shadow word shifts one place per bit so the outgoing bit is always at a fixed end.
    assign load_eff  = LOAD & ~AUTO;
    assign start_req = load_eff | pending_q | AUTO;
    assign first_bit = MSB ? DATA_IN[N_BITS-1] : DATA_IN[0];
    assign shadow_nx = MSB ? (shadow_q << 1) : (shadow_q >> 1);
    assign next_bit  = MSB ? shadow_nx[N_BITS-1] : shadow_nx[0];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        sdata_d   = sdata_q;
        strobe_d  = strobe_q;

        if (state_q != IDLE && load_eff) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start_req) begin
                    shadow_d  = DATA_IN;
                    idx_d     = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    sdata_d   = first_bit;
                    state_d   = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sclk_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        strobe_d = 1'b1;
                        state_d  = LATCH;
                    end else begin
                        shadow_d = shadow_nx;
                        sdata_d  = next_bit;
                        idx_d    = idx_q + 1'b1;
                        state_d  = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (tick) begin
                    strobe_d = 1'b0;
                    sdata_d  = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            strobe_q  <= strobe_d;
        end
    end

    // Frame data needs no reset: it is always reloaded before the first bit goes out.
    always_ff @(posedge CLK_IN) begin
        shadow_q <= shadow_d;
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SR_CLK    = sclk_q;
    assign SR_DATA   = sdata_q;
    assign SR_STROBE = strobe_q;

endmodule
